// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and NOP payload for pipeline stage registers.
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} stage_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating event counter, cleared only by reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered valid/ready stage register with flush and hold.
// PIPE_STAGE_PERF_EN builds the stall/flush saturating counters; otherwise they read 0.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(NOP_INSTR),
  parameter int                CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              in_fire, out_fire;
  // Ready depends only on local state, so upstream never sees a comb path from out_ready_i.
  assign in_ready_o  = (state_q != ST_FULL) && !hold_i;
  assign out_valid_o = (state_q != ST_EMPTY) && !hold_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;
  assign out_data_o  = (state_q == ST_EMPTY) ? FLUSH_VAL : main_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          main_d  = in_data_i;
          state_d = ST_ONE;
        end
        ST_ONE: if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          skid_d  = in_data_i;
          state_d = ST_FULL;
        end else if (out_fire) begin
          main_d  = FLUSH_VAL;
          state_d = ST_EMPTY;
        end
        ST_FULL: if (out_fire) begin
          main_d  = skid_q;
          skid_d  = FLUSH_VAL;
          state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid_o && !out_ready_i),
    .cnt_o (stall_cnt_o)
  );
  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_pipe_stage_reg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              hold_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [DATA_W-1:0] out_data_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;
  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .hold_i      (hold_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every completed output handshake must match the oldest expected payload.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mon_unexpected: got %h expected no output at %0t", out_data_o, $time);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          failures++;
          $display("FAIL mon_data: got %h expected %h at %0t", out_data_o, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk_i);
    chk("rst_valid", DATA_W'(out_valid_o), '0);
    chk("rst_data", out_data_o, '0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", DATA_W'(in_ready_o), 1);
    // Reset mid-stream: held entry lost, outputs clear immediately
    step();
    in_valid_i = 1'b1;
    in_data_i  = 16'h0011;
    step();
    in_valid_i = 1'b0;
    chk("pre_rst_valid", DATA_W'(out_valid_o), 1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", DATA_W'(out_valid_o), '0);
    chk("async_rst_data", out_data_o, '0);
    exp_q.delete();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", DATA_W'(in_ready_o), 1);
    chk("post_rst_valid", DATA_W'(out_valid_o), '0);
    // Stream 1..8 at full rate
    step();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data_i = DATA_W'(i);
      exp_q.push_back(DATA_W'(i));
      @(negedge clk_i);
      chk("stream_ready", DATA_W'(in_ready_o), 1);
      if (i == 1) chk("stream_first_empty", DATA_W'(out_valid_o), '0);
      else begin
        chk("stream_valid", DATA_W'(out_valid_o), 1);
        chk("stream_lat", out_data_o, DATA_W'(i - 1));
      end
      step();
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("stream_last", out_data_o, 16'd8);
    step();
    @(negedge clk_i);
    chk("stream_drained", DATA_W'(out_valid_o), '0);
    chk("stream_q_empty", DATA_W'(exp_q.size()), '0);
    // Backpressure: A,B fill the stage, C refused
    step();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h00A0;
    exp_q.push_back(16'h00A0);
    step();
    in_data_i = 16'h00B0;
    exp_q.push_back(16'h00B0);
    step();
    in_data_i = 16'h00C0;
    @(negedge clk_i);
    chk("bp_full_ready", DATA_W'(in_ready_o), '0);
    chk("bp_full_valid", DATA_W'(out_valid_o), 1);
    chk("bp_full_data", out_data_o, 16'h00A0);
    step();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_out_a", out_data_o, 16'h00A0);
    step();
    @(negedge clk_i);
    chk("bp_out_b", out_data_o, 16'h00B0);
    step();
    @(negedge clk_i);
    chk("bp_drained", DATA_W'(out_valid_o), '0);
    chk("bp_q_empty", DATA_W'(exp_q.size()), '0);
    // Flush while FULL drops A,B and the concurrent C
    step();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0A0A;
    step();
    in_data_i = 16'h0B0B;
    step();
    in_data_i = 16'h0C0C;
    flush_i   = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_valid", DATA_W'(out_valid_o), '0);
    chk("flush_data", out_data_o, '0);
    chk("flush_ready", DATA_W'(in_ready_o), 1);
    step();
    out_ready_i = 1'b1;
    step();
    step();
    @(negedge clk_i);
    chk("flush_stays_empty", DATA_W'(out_valid_o), '0);
    // Hold for 3 cycles with A held and new input offered
    step();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0D0A;
    exp_q.push_back(16'h0D0A);
    step();
    hold_i      = 1'b1;
    in_data_i   = 16'h0DDD;
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hold_valid", DATA_W'(out_valid_o), '0);
      chk("hold_ready", DATA_W'(in_ready_o), '0);
      step();
    end
    hold_i     = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("hold_release_valid", DATA_W'(out_valid_o), 1);
    chk("hold_release_data", out_data_o, 16'h0D0A);
    step();
    @(negedge clk_i);
    chk("hold_drained", DATA_W'(out_valid_o), '0);
    chk("hold_q_empty", DATA_W'(exp_q.size()), '0);
    // Perf counters from a fresh reset: 20 stalls, 2 flushes
    step();
    out_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i      = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = 16'h0E0E;
    step();
    in_valid_i = 1'b0;
    repeat (20) step();
    @(negedge clk_i);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall_sat", DATA_W'(stall_cnt_o), 16'd15);
`else
    chk("perf_stall_off", DATA_W'(stall_cnt_o), '0);
`endif
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_flush_cnt", DATA_W'(flush_cnt_o), 16'd2);
`else
    chk("perf_flush_off", DATA_W'(flush_cnt_o), '0);
`endif
    chk("final_q_empty", DATA_W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
